// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver core and the CPU register interface.
// First-word-fall-through head byte, fill level, almost-full and sticky overflow.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  rd_pop,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  clr_ovf,
    input  logic                  flush
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] AF_CNT    = AF_LEVEL[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]   count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  do_push, do_pop, drop;

    // A pop in the same edge frees a slot, so a push into a full FIFO is accepted then.
    always_comb begin
        do_pop  = !flush && rd_pop && !empty;
        do_push = !flush && wr_valid && (!full || do_pop);
        drop    = !flush && wr_valid && full && !do_pop;

        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        if (flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
            if (do_push && !do_pop)      count_next = count_reg + CNT_ONE;
            else if (do_pop && !do_push) count_next = count_reg - CNT_ONE;
            // A drop in the same cycle as clr_ovf must still be reported.
            if (drop)         overflow_next = 1'b1;
            else if (clr_ovf) overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage holds no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

    assign wr_ready    = 1'b1;
    assign count       = count_reg;
    assign empty       = (count_reg == '0);
    assign full        = (count_reg == DEPTH_CNT);
    assign almost_full = (count_reg >= AF_CNT);
    assign overflow    = overflow_reg;
    assign rd_data     = empty ? 8'h00 : mem[rd_ptr_reg];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default depth 16, AF_LEVEL 12).
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       rd_pop = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, almost_full, overflow;
    logic [4:0] count;
    logic       clr_ovf = 1'b0;
    logic       flush = 1'b0;

    int checks = 0;
    int passes = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4), .AF_LEVEL(12)) dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_pop(rd_pop), .rd_data(rd_data), .empty(empty),
        .full(full), .count(count), .almost_full(almost_full), .overflow(overflow),
        .clr_ovf(clr_ovf), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_data = b; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        $display("push %02h -> count=%0d", b, count);
    endtask

    task automatic pop();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        $display("pop -> count=%0d head=%02h", count, rd_data);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passes++;
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else passes++;
        checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %02h exp 00", rd_data); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passes++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b exp 1", wr_ready); else passes++;
        checks++; if (full !== 1'b0 || almost_full !== 1'b0)
            $display("FAIL reset_full_af got %b%b exp 00", full, almost_full); else passes++;
    endtask

    task automatic test_order();
        push(8'h41);
        checks++; if (rd_data !== 8'h41 || empty !== 1'b0)
            $display("FAIL order_first_visible got %02h/%b exp 41/0", rd_data, empty); else passes++;
        push(8'h42);
        push(8'h43);
        checks++; if (count !== 5'd3) $display("FAIL order_count got %0d exp 3", count); else passes++;
        pop();
        checks++; if (rd_data !== 8'h42) $display("FAIL order_second got %02h exp 42", rd_data); else passes++;
        pop();
        checks++; if (rd_data !== 8'h43) $display("FAIL order_third got %02h exp 43", rd_data); else passes++;
        pop();
        checks++; if (empty !== 1'b1 || count !== 5'd0 || rd_data !== 8'h00)
            $display("FAIL order_drained got e=%b c=%0d d=%02h exp 1/0/00", empty, count, rd_data); else passes++;
        pop();
        checks++; if (count !== 5'd0 || overflow !== 1'b0)
            $display("FAIL pop_empty got c=%0d o=%b exp 0/0", count, overflow); else passes++;
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            checks++;
            if (almost_full !== (i + 1 >= 12) || full !== (i + 1 == 16))
                $display("FAIL fill_flags n=%0d got af=%b f=%b", i + 1, almost_full, full);
            else passes++;
        end
        push(8'hAA);
        checks++; if (overflow !== 1'b1 || count !== 5'd16)
            $display("FAIL drop_flag got o=%b c=%0d exp 1/16", overflow, count); else passes++;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rd_data !== 8'(i)) $display("FAIL drain_order i=%0d got %02h exp %02h", i, rd_data, 8'(i));
            else passes++;
            pop();
        end
        checks++; if (empty !== 1'b1 || overflow !== 1'b1)
            $display("FAIL drain_end got e=%b o=%b exp 1/1", empty, overflow); else passes++;
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) $display("FAIL clr_ovf got %b exp 0", overflow); else passes++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        wr_data = 8'h55; wr_valid = 1'b1; rd_pop = 1'b1;
        tick();
        wr_valid = 1'b0; rd_pop = 1'b0;
        $display("push 55 + pop on full -> count=%0d", count);
        checks++; if (overflow !== 1'b0 || count !== 5'd16 || rd_data !== 8'h11)
            $display("FAIL full_pushpop got o=%b c=%0d d=%02h exp 0/16/11", overflow, count, rd_data); else passes++;
        for (int i = 1; i < 16; i++) pop();
        checks++; if (rd_data !== 8'h55 || count !== 5'd1)
            $display("FAIL full_pushpop_last got %02h c=%0d exp 55/1", rd_data, count); else passes++;
        pop();
    endtask

    task automatic test_empty_push_pop();
        wr_data = 8'h7E; wr_valid = 1'b1; rd_pop = 1'b1;
        tick();
        wr_valid = 1'b0; rd_pop = 1'b0;
        $display("push 7E + pop on empty -> count=%0d", count);
        checks++; if (count !== 5'd1 || rd_data !== 8'h7E)
            $display("FAIL empty_pushpop got c=%0d d=%02h exp 1/7E", count, rd_data); else passes++;
        for (int i = 0; i < 15; i++) push(8'(8'h60 + i));
        push(8'hEE);
        wr_data = 8'hEF; wr_valid = 1'b1; clr_ovf = 1'b1;
        tick();
        wr_valid = 1'b0; clr_ovf = 1'b0;
        $display("drop EF + clr_ovf -> overflow=%b", overflow);
        checks++; if (overflow !== 1'b1 || count !== 5'd16)
            $display("FAIL drop_beats_clr got o=%b c=%0d exp 1/16", overflow, count); else passes++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 11; i++) pop();
        checks++; if (count !== 5'd5 || overflow !== 1'b1 || rd_data !== 8'h6A)
            $display("FAIL pre_flush got c=%0d o=%b d=%02h exp 5/1/6A", count, overflow, rd_data); else passes++;
        flush = 1'b1; wr_data = 8'h33; wr_valid = 1'b1; rd_pop = 1'b1;
        tick();
        flush = 1'b0; wr_valid = 1'b0; rd_pop = 1'b0;
        $display("flush -> count=%0d", count);
        checks++; if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_data !== 8'h00)
            $display("FAIL flush got c=%0d e=%b o=%b d=%02h exp 0/1/0/00", count, empty, overflow, rd_data); else passes++;
        push(8'h99);
        checks++; if (rd_data !== 8'h99 || count !== 5'd1)
            $display("FAIL post_flush got %02h c=%0d exp 99/1", rd_data, count); else passes++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 15; i++) push(8'(8'hC0 + i));
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-cycle");
        checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
                      rd_data !== 8'h00 || overflow !== 1'b0)
            $display("FAIL async_reset got c=%0d e=%b f=%b af=%b d=%02h o=%b exp 0/1/0/0/00/0",
                     count, empty, full, almost_full, rd_data, overflow); else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        push(8'h5A);
        checks++; if (rd_data !== 8'h5A || count !== 5'd1)
            $display("FAIL after_reset got %02h c=%0d exp 5A/1", rd_data, count); else passes++;
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
